// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with first-word fall-through receive FIFO
//
// Oversampled UART receiver: a 2-flop synchroniser feeds a bit-timing FSM
// (IDLE, START, DATA, PAR, STOP, WAIT_IDLE). Good frames are pushed into a
// small FIFO. Frames that fail framing or parity checks are dropped, and so
// are good frames that arrive while the FIFO is full.
//
// Optional feature macro: UART_RX_BREAK_DET_EN
//   When defined, the brk output is added. An all-zero frame (data, parity
//   and stop all low) pulses brk instead of frame_err.
//
// Ports:
//   HCLK        in   system clock, rising edge
//   HRESETn     in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to HCLK
//   rd_data     out  FIFO head word, zero while the FIFO is empty
//   rd_valid    out  FIFO not empty
//   rd_ready    in   pop request, acted on only while rd_valid is high
//   fifo_level  out  FIFO occupancy
//   frame_err   out  one-cycle pulse, stop bit sampled low
//   parity_err  out  one-cycle pulse, parity mismatch
//   overrun     out  one-cycle pulse, good frame dropped on a full FIFO
//   brk         out  one-cycle pulse, break detected (macro builds only)
//   busy        out  receiver FSM not in IDLE

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 8,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 brk,
`endif
  output logic                 busy
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  // Synchroniser and edge-detect history. All three reset to the idle level,
  // so coming out of reset never produces a spurious falling edge.
  logic rx_meta_q, rxs_q, rxs_prev_q;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                 par_bit_q, par_bit_d;
  logic                 brk_q, brk_d;
`endif

  logic                 tick;
  logic                 push;
  logic                 pop;
  logic                 full;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     count_q;

  assign tick = (baud_q == '0);
  assign full = (count_q == LVL_W'(FIFO_DEPTH));
  assign pop  = rd_valid && rd_ready;

  // -------------------------------------------------------------------------
  // Receiver FSM, next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    push         = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    par_bit_d    = par_bit_q;
    brk_d        = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        // A half-bit countdown puts every later sample at mid-bit.
        if (rxs_prev_q && !rxs_q) begin
          state_d = S_START;
          baud_d  = BAUD_HALF;
        end
      end

      S_START: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else if (rxs_q) begin
          // Line is back high at mid start bit: a glitch, not a frame.
          state_d = S_IDLE;
        end else begin
          state_d   = S_DATA;
          baud_d    = BAUD_FULL;
          bit_d     = '0;
          par_err_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          par_bit_d = 1'b0;
`endif
        end
      end

      S_DATA: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          // LSB arrives first, so it is shifted in from the top and ends up
          // at bit 0 once all DATA_BITS samples are in.
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          baud_d  = BAUD_FULL;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_PAR: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          // Even: data ^ parity must be 0. Odd: it must be 1.
          par_err_d = ((^shift_q) ^ rxs_q) != (PARITY == 2);
`ifdef UART_RX_BREAK_DET_EN
          par_bit_d = rxs_q;
`endif
          state_d   = S_STOP;
          baud_d    = BAUD_FULL;
        end
      end

      S_STOP: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else if (!rxs_q) begin
`ifdef UART_RX_BREAK_DET_EN
          if ((shift_q == '0) && !par_bit_q) begin
            brk_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
`else
          frame_err_d = 1'b1;
`endif
          state_d = S_WAIT_IDLE;
        end else if (par_err_q) begin
          parity_err_d = 1'b1;
          state_d      = S_IDLE;
        end else if (full && !pop) begin
          overrun_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        // Hold here so a line stuck low reports only one error.
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Receiver state registers
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q    <= 1'b0;
      brk_q        <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rxs_q        <= rx_meta_q;
      rxs_prev_q   <= rxs_q;
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q    <= par_bit_d;
      brk_q        <= brk_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Receive FIFO. A push is only issued when there is room or a pop happens
  // in the same cycle, so the count never exceeds FIFO_DEPTH.
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rd_valid   = (count_q != '0);
  // Storage is not reset, so the head is masked to zero while empty.
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_BREAK_DET_EN
  assign brk        = brk_q;
`endif
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable, parametrised UART receiver with a receive FIFO. Successor to the behavioural serial terminal used on the SoC bench.
- Adds configurable data width, parity, baud divisor, error flagging and buffered readout.
- Attaches to any UART TX line, e.g. the SoC UART0 TX. Usable in the DV bench and on FPGA as a loopback/console capture block.

Parameters:
- CLKS_PER_BIT, 16, HCLK cycles per serial bit; minimum 4, must be even.
- DATA_BITS, 8, payload bits per frame, 5 to 9, LSB first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH, 8, receive FIFO entries, power of two, at least 2.

Ports:
- HCLK  input  1  system clock, all state on rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- rx  input  1  serial input, idle high, asynchronous to HCLK.
- rd_data  output  DATA_BITS  FIFO head word (first-word fall-through).
- rd_valid  output  1  FIFO not empty.
- rd_ready  input  1  pop; head consumed on a cycle where rd_valid && rd_ready.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err  output  1  one-cycle pulse, stop bit sampled low.
- parity_err  output  1  one-cycle pulse, parity mismatch.
- overrun  output  1  one-cycle pulse, good frame dropped because the FIFO was full.
- busy  output  1  high while not in IDLE.

Behaviour:
- Clock, reset and synchronisation:
  - One clock; reset is asynchronous and active-low on HCLK/HRESETn.
  - rx passes through a 2-flop synchroniser, reset to 1. All decisions use the synchronised value rxs.
- Reset values: rd_valid=0, fifo_level=0, frame_err=parity_err=overrun=0, busy=0, rd_data=0. FIFO pointers cleared, FSM in IDLE, bit counter and baud counter 0.
- States IDLE, START, DATA, PAR, STOP, WAIT_IDLE. Baud counter reloads to CLKS_PER_BIT-1 at each sample point.
- IDLE: on rxs falling (1 to 0), go to START and load CLKS_PER_BIT/2-1.
- START: at count 0, sample rxs.
  - If 1: false start, return to IDLE, no flags.
  - If 0: go to DATA.
- DATA: sample DATA_BITS bits, one per CLKS_PER_BIT, shifting LSB first. Then go to PAR if PARITY!=0, else STOP.
- PAR: sample the parity bit.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Odd parity: that XOR must be 1.
  - Store the mismatch result; go to STOP.
- STOP: sample rxs.
  - If 0: frame_err pulses, byte dropped, go to WAIT_IDLE.
  - Else if parity mismatch: parity_err pulses, byte dropped, go to IDLE.
  - Else if FIFO full and no pop this cycle: overrun pulses, byte dropped, FIFO contents unchanged.
  - Else: push the byte. Go to IDLE.
  - Frame_err takes priority over parity_err; only one error flag pulses per frame.
- WAIT_IDLE: stay until rxs=1, then IDLE. A held-low line yields exactly one frame_err.
- Latency: a pushed byte appears on rd_data with rd_valid=1 the cycle after the stop sample point.
- FIFO:
  - Full: push and pop in the same cycle both succeed; level unchanged.
  - Empty: rd_ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level updates the cycle after push/pop.
- A glitch shorter than CLKS_PER_BIT/2 on idle rx is rejected as a false start.
- Reset mid-frame: the partial frame is discarded and FIFO contents are lost.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- When defined:
  - Adds output brk (1 bit, reset 0).
  - If the data bits are all 0 (and parity bit 0, if present) and the stop bit is 0, brk pulses for one cycle instead of frame_err. No push; go to WAIT_IDLE.
- When undefined:
  - No brk port.
  - A break is reported as frame_err.

Test Plan:
- Default params. Drive 0x55, 8N1, bit time 16 cycles -> rd_valid rises 152–155 cycles after the rx falling edge, rd_data=0x55, no error flags, fifo_level=1.
- Send 0x01..0x09 with rd_ready=0, FIFO_DEPTH=8 -> level reaches 8, overrun pulses once on the 9th. Pop all -> 0x01..0x08 in order, level returns to 0.
- FIFO full. Complete a frame of 0xA5 on the same cycle rd_ready=1 -> no overrun, level stays 8, last entry 0xA5.
- PARITY=1. Send 0x03 with parity bit 1 -> parity_err pulses once, level unchanged. Send 0x03 with parity 0 -> stored.
- Stop bit forced 0 on 0x7E -> frame_err once, nothing stored. 4-cycle low glitch on idle line -> no state change, busy returns 0 within 8 cycles.
- UART_RX_BREAK_DET_EN defined, rx held low for 20 bit times -> brk pulses once, frame_err stays 0. Next valid 0x41 is received correctly after rx returns high.
